// File: rtl/vscale_rr_dmem_arbiter_if.sv
// vscale_rr_dmem_arbiter_if: flattened core-side and dmem-side HASTI signals of the shared dmem arbiter
interface vscale_rr_dmem_arbiter_if #(
  parameter int NUM_CORES  = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32
);
  logic [NUM_CORES*ADDR_WIDTH-1:0] core_haddr;
  logic [NUM_CORES-1:0]            core_hwrite;
  logic [NUM_CORES*3-1:0]          core_hsize;
  logic [NUM_CORES*2-1:0]          core_htrans;
  logic [NUM_CORES*BUS_WIDTH-1:0]  core_hwdata;
  logic [NUM_CORES*BUS_WIDTH-1:0]  core_hrdata;
  logic [NUM_CORES-1:0]            core_hready;
  logic [NUM_CORES-1:0]            core_hresp;
  logic [ADDR_WIDTH-1:0]           dmem_haddr;
  logic                            dmem_hwrite;
  logic [2:0]                      dmem_hsize;
  logic [1:0]                      dmem_htrans;
  logic [2:0]                      dmem_hburst;
  logic                            dmem_hmastlock;
  logic [3:0]                      dmem_hprot;
  logic [BUS_WIDTH-1:0]            dmem_hwdata;
  logic [BUS_WIDTH-1:0]            dmem_hrdata;
  logic                            dmem_hready;
  logic                            dmem_hresp;
  logic                            grant_valid;
  logic [IDX_WIDTH-1:0]            grant_idx;
  modport slave (
    input  core_haddr, core_hwrite, core_hsize, core_htrans, core_hwdata,
    input  dmem_hrdata, dmem_hready, dmem_hresp,
    output core_hrdata, core_hready, core_hresp,
    output dmem_haddr, dmem_hwrite, dmem_hsize, dmem_htrans, dmem_hburst,
    output dmem_hmastlock, dmem_hprot, dmem_hwdata, grant_valid, grant_idx
  );
  modport master (
    output core_haddr, core_hwrite, core_hsize, core_htrans, core_hwdata,
    output dmem_hrdata, dmem_hready, dmem_hresp,
    input  core_hrdata, core_hready, core_hresp,
    input  dmem_haddr, dmem_hwrite, dmem_hsize, dmem_htrans, dmem_hburst,
    input  dmem_hmastlock, dmem_hprot, dmem_hwdata, grant_valid, grant_idx
  );
endinterface

// File: rtl/vscale_rr_dmem_arbiter.sv
// vscale_rr_dmem_arbiter: buffered round-robin arbiter sharing one HASTI dmem port among vscale cores
module vscale_rr_dmem_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32
) (
  input logic                     hclk,
  input logic                     hresetn,
  vscale_rr_dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_DATA} state_t;
  logic [NUM_CORES-1:0]  w_pend, w_data, w_buf_write;
  logic [ADDR_WIDTH-1:0] w_buf_addr [NUM_CORES];
  logic [2:0]            w_buf_size [NUM_CORES];
  logic [IDX_WIDTH-1:0]  r_rr_ptr, r_owner, w_sel, w_scan;
  logic                  r_owner_valid, w_grant, w_unused;
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic                  w_latch;
    assign w_latch = bus.core_htrans[2*i+1] && (r_state == S_IDLE || (r_state == S_DATA && bus.dmem_hready));
    // capture the core's address phase, then walk it through PEND and DATA
    always_ff @(posedge hclk or negedge hresetn)
      if (!hresetn) begin
        r_state <= S_IDLE;
        r_addr  <= '0;
        r_write <= 1'b0;
        r_size  <= '0;
      end else begin
        if (w_latch) begin
          r_addr  <= bus.core_haddr[ADDR_WIDTH*i +: ADDR_WIDTH];
          r_write <= bus.core_hwrite[i];
          r_size  <= bus.core_hsize[3*i +: 3];
        end
        r_state <= w_latch ? S_PEND
                 : (r_state == S_PEND && w_grant && w_sel == IDX_WIDTH'(i)) ? S_DATA
                 : (r_state == S_DATA && bus.dmem_hready) ? S_IDLE
                 : r_state;
      end
    assign w_pend[i]      = r_state == S_PEND;
    assign w_data[i]      = r_state == S_DATA;
    assign w_buf_addr[i]  = r_addr;
    assign w_buf_write[i] = r_write;
    assign w_buf_size[i]  = r_size;
    assign bus.core_hready[i] = r_state == S_IDLE || (w_data[i] && bus.dmem_hready);
    assign bus.core_hrdata[BUS_WIDTH*i +: BUS_WIDTH] = w_data[i] ? bus.dmem_hrdata : '0;
    assign bus.core_hresp[i] = w_data[i] && bus.dmem_hresp;
  end
  // pick the first pending core at or after the round-robin pointer
  always_comb begin
    w_grant = 1'b0;
    w_sel   = '0;
    w_scan  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_scan = IDX_WIDTH'((int'(r_rr_ptr) + k) % NUM_CORES);
      if (!w_grant && bus.dmem_hready && w_pend[w_scan]) begin
        w_grant = 1'b1;
        w_sel   = w_scan;
      end
    end
  end
  // advance the pointer past each grant and remember who owns the data phase
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      r_rr_ptr      <= '0;
      r_owner       <= '0;
      r_owner_valid <= 1'b0;
    end else if (bus.dmem_hready) begin
      r_owner_valid <= w_grant;
      if (w_grant) begin
        r_owner  <= w_sel;
        r_rr_ptr <= (w_sel == IDX_WIDTH'(NUM_CORES-1)) ? '0 : w_sel + 1'b1;
      end
    end
  assign bus.dmem_haddr     = w_grant ? w_buf_addr[w_sel] : '0;
  assign bus.dmem_hwrite    = w_grant && w_buf_write[w_sel];
  assign bus.dmem_hsize     = w_grant ? w_buf_size[w_sel] : 3'd0;
  assign bus.dmem_htrans    = w_grant ? 2'b10 : 2'b00;
  assign bus.dmem_hburst    = 3'd0;
  assign bus.dmem_hmastlock = 1'b0;
  assign bus.dmem_hprot     = 4'd0;
  assign bus.dmem_hwdata    = r_owner_valid ? bus.core_hwdata[BUS_WIDTH*r_owner +: BUS_WIDTH] : '0;
  assign bus.grant_valid    = w_grant;
  assign bus.grant_idx      = w_sel;
  assign w_unused           = ^bus.core_htrans;
endmodule

// File: tb/tb_vscale_rr_dmem_arbiter.sv
// tb_vscale_rr_dmem_arbiter: directed scenarios with a transaction-level model checked every cycle
module tb_vscale_rr_dmem_arbiter;
  localparam int N = 4, IW = 2, AW = 32, BW = 32;
  typedef struct { logic [AW-1:0] addr; logic wr; logic [BW-1:0] data; } req_t;
  logic hclk = 1'b0, hresetn = 1'b1;
  int n_pass = 0, n_total = 0;
  req_t cq [N][$];
  logic [BW-1:0] wdata [N];
  logic acc [N];
  int glog [$];
  bit m_pend [N], n_pend [N];
  logic [AW-1:0] m_addr [N], n_addr [N];
  logic m_wr [N], n_wr [N];
  logic [2:0] m_sz [N], n_sz [N];
  int m_own = -1, n_own = -1, m_ptr = 0, n_ptr = 0;
  always #5 hclk = ~hclk;
  vscale_rr_dmem_arbiter_if #(.NUM_CORES(N), .IDX_WIDTH(IW), .ADDR_WIDTH(AW), .BUS_WIDTH(BW)) bus ();
  vscale_rr_dmem_arbiter #(.NUM_CORES(N), .IDX_WIDTH(IW), .ADDR_WIDTH(AW), .BUS_WIDTH(BW)) dut (
    .hclk(hclk), .hresetn(hresetn), .bus(bus)
  );
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask
  // model: a core's address phase is taken whenever it sees hready; grants go round-robin over waiting requests
  always @(negedge hclk) begin
    bit p [N];
    int own, ptr, sel;
    bit a;
    logic [N-1:0] er, es;
    logic [N*BW-1:0] ed;
    p = m_pend;
    own = m_own;
    ptr = m_ptr;
    if (!hresetn) begin
      foreach (p[i]) p[i] = 1'b0;
      own = -1;
      ptr = 0;
    end
    sel = -1;
    if (hresetn && bus.dmem_hready)
      for (int k = 0; k < N; k++)
        if (sel < 0 && p[(ptr + k) % N]) sel = (ptr + k) % N;
    for (int i = 0; i < N; i++) begin
      er[i] = (i == own) ? bus.dmem_hready : !p[i];
      es[i] = (i == own) && bus.dmem_hresp;
      ed[BW*i +: BW] = (i == own) ? bus.dmem_hrdata : '0;
    end
    chk("core_hready", bus.core_hready, er);
    chk("core_hresp", bus.core_hresp, es);
    chk("core_hrdata", bus.core_hrdata, ed);
    chk("dmem_htrans", bus.dmem_htrans, sel >= 0 ? 2'b10 : 2'b00);
    chk("grant_valid", bus.grant_valid, sel >= 0);
    chk("dmem_consts", {bus.dmem_hburst, bus.dmem_hmastlock, bus.dmem_hprot}, '0);
    if (sel >= 0) begin
      chk("addr_phase", {bus.grant_idx, bus.dmem_hwrite, bus.dmem_hsize, bus.dmem_haddr},
          {IW'(sel), m_wr[sel], m_sz[sel], m_addr[sel]});
      glog.push_back(int'(bus.grant_idx));
    end
    if (own >= 0) chk("dmem_hwdata", bus.dmem_hwdata, bus.core_hwdata[BW*own +: BW]);
    n_addr = m_addr;
    n_wr = m_wr;
    n_sz = m_sz;
    for (int i = 0; i < N; i++) begin
      a = hresetn && er[i] && bus.core_htrans[2*i+1];
      n_pend[i] = a || (p[i] && i != sel);
      if (a) begin
        n_addr[i] = bus.core_haddr[AW*i +: AW];
        n_wr[i] = bus.core_hwrite[i];
        n_sz[i] = bus.core_hsize[3*i +: 3];
      end
    end
    n_own = !hresetn ? -1 : bus.dmem_hready ? sel : own;
    n_ptr = sel >= 0 ? (sel + 1) % N : ptr;
  end
  always @(posedge hclk) begin
    m_pend <= n_pend;
    m_addr <= n_addr;
    m_wr <= n_wr;
    m_sz <= n_sz;
    m_own <= n_own;
    m_ptr <= n_ptr;
  end
  task automatic present();
    for (int i = 0; i < N; i++) begin
      if (cq[i].size() > 0) begin
        bus.core_htrans[2*i +: 2] = 2'b10;
        bus.core_haddr[AW*i +: AW] = cq[i][0].addr;
        bus.core_hwrite[i] = cq[i][0].wr;
      end else begin
        bus.core_htrans[2*i +: 2] = 2'b00;
        bus.core_haddr[AW*i +: AW] = '0;
        bus.core_hwrite[i] = 1'b0;
      end
      bus.core_hsize[3*i +: 3] = 3'(i);
      bus.core_hwdata[BW*i +: BW] = wdata[i];
    end
  endtask
  task automatic push(input int c, input logic [AW-1:0] a, input logic w, input logic [BW-1:0] d);
    req_t r;
    r.addr = a;
    r.wr = w;
    r.data = d;
    cq[c].push_back(r);
    present();
  endtask
  task automatic step();
    @(negedge hclk);
    for (int i = 0; i < N; i++) acc[i] = hresetn && bus.core_hready[i] && bus.core_htrans[2*i+1];
    @(posedge hclk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        wdata[i] = cq[i][0].data;
        void'(cq[i].pop_front());
      end
    present();
  endtask
  task automatic do_reset();
    @(posedge hclk);
    #2;
    hresetn = 1'b0;
    #1;
    chk("reset hready", bus.core_hready, 4'hF);
    chk("reset hresp", bus.core_hresp, 4'h0);
    chk("reset hrdata", bus.core_hrdata, '0);
    chk("reset htrans", bus.dmem_htrans, 2'b00);
    chk("reset grant_valid", bus.grant_valid, 1'b0);
    chk("reset grant_idx", bus.grant_idx, 2'd0);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
  endtask
  initial begin
    foreach (wdata[i]) wdata[i] = '0;
    bus.core_haddr = '0;
    bus.core_hwrite = '0;
    bus.core_hsize = '0;
    bus.core_htrans = '0;
    bus.core_hwdata = '0;
    bus.dmem_hrdata = '0;
    bus.dmem_hready = 1'b1;
    bus.dmem_hresp = 1'b0;
    do_reset();
    bus.dmem_hrdata = 32'hDEADBEEF;
    push(2, 32'h100, 1'b0, '0);
    step(); #2;
    chk("single htrans", bus.dmem_htrans, 2'b10);
    chk("single haddr", bus.dmem_haddr, 32'h100);
    chk("single grant_idx", bus.grant_idx, 2'd2);
    chk("single pend hready", bus.core_hready, 4'b1011);
    step(); #2;
    chk("single data hready", bus.core_hready, 4'hF);
    chk("single hrdata", bus.core_hrdata[BW*2 +: BW], 32'hDEADBEEF);
    step(); step();
    do_reset();
    bus.dmem_hrdata = 32'h5A5A0001;
    for (int c = 0; c < N; c++) push(c, 32'h200 + 32'(16*c), 1'b0, '0);
    for (int g = 0; g < N; g++) begin
      step(); #2;
      chk("rr order", {bus.grant_valid, bus.grant_idx}, {1'b1, IW'(g)});
    end
    step();
    push(3, 32'h300, 1'b0, '0);
    push(0, 32'h304, 1'b0, '0);
    step(); #2;
    chk("rr wrap to 0", bus.grant_idx, 2'd0);
    step(); step(); step();
    glog.delete();
    bus.dmem_hrdata = 32'h0BAD0F00;
    for (int k = 0; k < 4; k++) push(0, 32'h400 + 32'(4*k), 1'b0, '0);
    push(1, 32'h500, 1'b0, '0);
    repeat (8) step();
    #2;
    chk("contention grants", glog.size(), 5);
    chk("contention g0", glog.size() > 0 ? glog[0] : 99, 0);
    chk("contention g1", glog.size() > 1 ? glog[1] : 99, 1);
    chk("contention g2", glog.size() > 2 ? glog[2] : 99, 0);
    step();
    push(3, 32'h40, 1'b1, 32'h12345678);
    step(); #2;
    chk("write hwrite", {bus.dmem_hwrite, bus.dmem_haddr}, {1'b1, 32'h40});
    chk("write grant_idx", bus.grant_idx, 2'd3);
    step(); #2;
    chk("write hwdata", bus.dmem_hwdata, 32'h12345678);
    step(); step();
    push(1, 32'h600, 1'b0, '0);
    step(); #2;
    chk("wait grant1", bus.grant_idx, 2'd1);
    push(2, 32'h700, 1'b0, '0);
    for (int s = 0; s < 2; s++) begin
      step();
      bus.dmem_hready = 1'b0;
      #2;
      chk("wait no grant", bus.grant_valid, 1'b0);
      chk("wait hready", bus.core_hready, 4'b1001);
    end
    step();
    bus.dmem_hready = 1'b1;
    bus.dmem_hresp = 1'b1;
    #2;
    chk("wait release hready", bus.core_hready, 4'b1011);
    chk("error forwarded", bus.core_hresp, 4'b0010);
    chk("wait buffered grant", {bus.grant_idx, bus.dmem_haddr}, {2'd2, 32'h700});
    step();
    bus.dmem_hresp = 1'b0;
    step(); step();
    push(1, 32'h800, 1'b0, '0);
    push(2, 32'h900, 1'b0, '0);
    step(); #2;
    chk("midrst grant1", bus.grant_idx, 2'd1);
    step();
    bus.dmem_hready = 1'b0;
    #1;
    chk("midrst before", bus.core_hready, 4'b1001);
    hresetn = 1'b0;
    #1;
    chk("midrst hready", bus.core_hready, 4'hF);
    chk("midrst htrans", {bus.grant_valid, bus.dmem_htrans}, 3'b000);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    bus.dmem_hready = 1'b1;
    push(3, 32'hA00, 1'b0, '0);
    push(1, 32'hB00, 1'b0, '0);
    step(); #2;
    chk("midrst first", bus.grant_idx, 2'd1);
    step(); #2;
    chk("midrst second", bus.grant_idx, 2'd3);
    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
